// File: rtl/u_rec_pkg.sv
// Shared RS232 definitions: line levels, word length and the FSM state
// encodings for both the transmitter (x_*) and the receiver (r_*).
package u_rec_pkg;

    localparam logic LO = 1'b0;
    localparam logic HI = 1'b1;

    localparam int WORD_LEN = 8;

    typedef enum logic [2:0] {
        x_IDLE  = 3'd0,
        x_START = 3'd1,
        x_DATA  = 3'd2,
        x_STOP  = 3'd3
    } xmit_state_e;

    typedef enum logic [2:0] {
        r_IDLE  = 3'd0,
        r_START = 3'd1,
        r_DATA  = 3'd2,
        r_STOP  = 3'd3,
        r_BREAK = 3'd4
    } rec_state_e;

endpackage

// File: rtl/u_rec_sync.sv
// Two-flop synchroniser for the asynchronous serial line. Both flops reset
// to the idle (HI) level so a reset never looks like a start bit.
module u_rec_sync
    import u_rec_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw line through two flops; reset both to the idle level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= HI;
            sync_q <= HI;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/u_rec.sv
// UART receiver: deserialises a 16x-oversampled line (start, WORD_LEN data
// bits LSB first, stop) and hands each word to the host with valid/ack.
module u_rec #(
    parameter int WORD_LEN  = u_rec_pkg::WORD_LEN,
    parameter int BIT_CELL  = 16,
    parameter int HALF_CELL = BIT_CELL / 2
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                uart_recH,
    input  logic                rec_ackH,
    output logic [WORD_LEN-1:0] rec_dataH,
    output logic                rec_validH,
    output logic                frame_errH,
    output logic                overrunH,
    output logic                rec_busyH
);

    import u_rec_pkg::*;

    localparam int CW = $clog2(BIT_CELL);
    localparam int BW = $clog2(WORD_LEN + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CELL - 1);
    localparam logic [CW-1:0] CELL_LAST = CW'(BIT_CELL - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_LEN - 1);

    logic                rx_s;

    rec_state_e          state_q, state_d;
    logic [CW-1:0]       cell_q, cell_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [WORD_LEN-1:0] shift_q, shift_d;
    logic [WORD_LEN-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;

    u_rec_sync u_sync (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .d_i   (uart_recH),
        .q_o   (rx_s)
    );

    // Frame FSM and datapath next-state: centre-samples each bit cell and
    // resolves the stop bit into either a delivered word or a framing error.
    always_comb begin
        state_d = state_q;
        cell_d  = cell_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~rec_ackH;
        ferr_d  = LO;
        ovr_d   = LO;

        case (state_q)
            r_IDLE: begin
                cell_d = '0;
                bit_d  = '0;
                if (rx_s == LO) begin
                    state_d = r_START;
                end
            end

            r_START: begin
                if (cell_q == HALF_LAST) begin
                    cell_d  = '0;
                    state_d = (rx_s == LO) ? r_DATA : r_IDLE;
                end
            end

            r_DATA: begin
                if (cell_q == CELL_LAST) begin
                    cell_d  = '0;
                    shift_d = {rx_s, shift_q[WORD_LEN-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = r_STOP;
                    end
                end
            end

            r_STOP: begin
                if (cell_q == CELL_LAST) begin
                    cell_d = '0;
                    if (rx_s == HI) begin
                        data_d  = shift_q;
                        valid_d = HI;
                        ovr_d   = valid_q & ~rec_ackH;
                        state_d = r_IDLE;
                    end else begin
                        ferr_d  = HI;
                        state_d = r_BREAK;
                    end
                end
            end

            r_BREAK: begin
                cell_d = '0;
                bit_d  = '0;
                if (rx_s == HI) begin
                    state_d = r_IDLE;
                end
            end

            default: begin
                state_d = r_IDLE;
                cell_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Register all receiver state; a reset aborts any frame in progress.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= r_IDLE;
            cell_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= LO;
            ferr_q  <= LO;
            ovr_q   <= LO;
        end else begin
            state_q <= state_d;
            cell_q  <= cell_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rec_dataH  = data_q;
    assign rec_validH = valid_q;
    assign frame_errH = ferr_q;
    assign overrunH   = ovr_q;
    assign rec_busyH  = (state_q != r_IDLE);

endmodule
